// File: rtl/proc_pkg.sv
// Shared processor definitions: instruction fields, opcodes and the issue FSM encoding.
package proc_pkg;

  localparam int INSTR_W = 16;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WB,
    ST_DONE
  } issue_state_e;

  function automatic logic is_halt(input logic [INSTR_W-1:0] w);
    return w[OPC_MSB:OPC_LSB] == OP_HALT;
  endfunction

endpackage

// File: rtl/instr_buffer.sv
// Program store: register array with one write port and one asynchronous read port.
module instr_buffer #(
  parameter int DEPTH = 16,
  parameter int W     = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  // Storage is deliberately not reset; the issuer's count decides which entries are valid.
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_issuer.sv
// Buffered instruction sequencer: loads a program, then replays it to decode over
// valid/ready with one write-back gap cycle after each accepted word.
module instr_issuer #(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = proc_pkg::INSTR_W,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_instr,
  output logic               load_ready,
  input  logic               start,
  input  logic               clear,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_word,
  input  logic               instr_ready,
  output logic [AW-1:0]      pc,
  output logic [CW-1:0]      count,
  output logic               busy,
  output logic               done
);
  import proc_pkg::*;

  issue_state_e       state, state_nx;
  logic [AW-1:0]      pc_nx, pc_inc, rd_addr;
  logic [CW-1:0]      count_nx;
  logic               valid_nx, load_fire, we;
  logic [INSTR_W-1:0] word_nx, rd_data, fetch;

  instr_buffer #(.DEPTH(DEPTH), .W(INSTR_W)) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (count[AW-1:0]),
    .wdata (load_instr),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign load_ready = (state == ST_IDLE) && (count < CW'(DEPTH));
  assign load_fire  = load_valid && load_ready;
  assign we         = load_fire && !clear;
  assign pc_inc     = pc + AW'(1);
  assign rd_addr    = (state == ST_WB) ? pc_inc : '0;
  // A start that coincides with the very first load must see that word before it lands.
  assign fetch      = (state == ST_IDLE && load_fire && count == '0) ? load_instr : rd_data;

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    count_nx = count;
    valid_nx = instr_valid;
    word_nx  = instr_word;
    case (state)
      ST_IDLE: begin
        if (clear) begin
          count_nx = '0;
          pc_nx    = '0;
        end else begin
          if (load_fire) count_nx = count + CW'(1);
          if (start && (count != '0 || load_fire)) begin
            state_nx = ST_RUN;
            pc_nx    = '0;
            word_nx  = fetch;
            valid_nx = !is_halt(fetch);
          end
        end
      end
      ST_RUN: begin
        // A HALT word is latched but never offered.
        if (!instr_valid) begin
          state_nx = ST_DONE;
        end else if (instr_ready) begin
          state_nx = ST_WB;
          valid_nx = 1'b0;
        end
      end
      ST_WB: begin
        if (CW'(pc) + CW'(1) == count) begin
          state_nx = ST_DONE;
        end else begin
          state_nx = ST_RUN;
          pc_nx    = pc_inc;
          word_nx  = fetch;
          valid_nx = !is_halt(fetch);
        end
      end
      ST_DONE: begin
        if (clear) begin
          state_nx = ST_IDLE;
          count_nx = '0;
          pc_nx    = '0;
        end else if (start) begin
          state_nx = ST_RUN;
          pc_nx    = '0;
          word_nx  = fetch;
          valid_nx = !is_halt(fetch);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= '0;
      count       <= '0;
      instr_valid <= 1'b0;
      instr_word  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      count       <= count_nx;
      instr_valid <= valid_nx;
      instr_word  <= word_nx;
      busy        <= (state_nx == ST_RUN) || (state_nx == ST_WB);
      done        <= (state_nx == ST_DONE);
    end
  end

endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer: load/replay, full buffer, HALT, stall, clear and async reset.
module tb_instr_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid, start, clear, instr_ready;
  logic [15:0] load_instr;
  logic        load_ready, instr_valid, busy, done;
  logic [15:0] instr_word;
  logic [3:0]  pc;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_issuer #(.DEPTH(16), .INSTR_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_instr  (load_instr),
    .load_ready  (load_ready),
    .start       (start),
    .clear       (clear),
    .instr_valid (instr_valid),
    .instr_word  (instr_word),
    .instr_ready (instr_ready),
    .pc          (pc),
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [15:0] w);
    load_valid = 1'b1;
    load_instr = w;
    step();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, instr_valid, 0);
    chk({tag, "_word"},  instr_word, 0);
    chk({tag, "_pc"},    pc, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_lrdy"},  load_ready, 1);
  endtask

  initial begin
    int issued, bad, n;
    rst = 1'b1; load_valid = 0; load_instr = 0; start = 0; clear = 0; instr_ready = 1;
    step(); step();
    chk_reset_vals("rst");
    rst = 1'b0;
    step();

    // Three-word program, cycle-exact
    load_word(16'h1123); load_word(16'h6452); load_word(16'h0312);
    chk("t1_count_pre", count, 3);
    pulse_start();
    chk("t1_v0", instr_valid, 1); chk("t1_w0", instr_word, 16'h1123); chk("t1_pc0", pc, 0);
    chk("t1_busy", busy, 1);
    step(); chk("t1_wb0", instr_valid, 0); chk("t1_wb_busy", busy, 1);
    step(); chk("t1_v1", instr_valid, 1); chk("t1_w1", instr_word, 16'h6452); chk("t1_pc1", pc, 1);
    step(); chk("t1_wb1", instr_valid, 0);
    step(); chk("t1_v2", instr_valid, 1); chk("t1_w2", instr_word, 16'h0312); chk("t1_pc2", pc, 2);
    step(); chk("t1_wb2_done", done, 0);
    step(); chk("t1_done", done, 1); chk("t1_nbusy", busy, 0); chk("t1_count", count, 3);
    chk("t1_lrdy_done", load_ready, 0);

    // Full buffer, overflow attempt, full replay
    pulse_clear();
    chk("t2_clr_count", count, 0); chk("t2_clr_done", done, 0);
    for (int i = 0; i < 16; i++) load_word(16'h1000 + 16'(i));
    chk("t2_full_lrdy", load_ready, 0); chk("t2_count16", count, 16);
    load_word(16'h1999);
    chk("t2_count_ovf", count, 16);
    pulse_start();
    issued = 0; n = 0;
    while (!done && n < 60) begin
      if (instr_valid) begin
        chk("t2_pc", pc, issued);
        chk("t2_word", instr_word, 16'h1000 + 16'(issued));
        issued++;
      end
      step(); n++;
    end
    chk("t2_done", done, 1); chk("t2_issued", issued, 16); chk("t2_pc_end", pc, 15);

    // HALT stops issue
    pulse_clear();
    load_word(16'h0123); load_word(16'hF000); load_word(16'h0456);
    pulse_start();
    issued = 0; bad = 0; n = 0;
    while (!done && n < 20) begin
      if (instr_valid) begin
        issued++;
        if (instr_word != 16'h0123) bad++;
      end
      step(); n++;
    end
    chk("t3_done", done, 1); chk("t3_issued", issued, 1); chk("t3_bad", bad, 0);
    chk("t3_pc", pc, 1);
    step(); chk("t3_stay_done", done, 1); chk("t3_no_valid", instr_valid, 0);

    // Stall for 5 cycles, transfer on the 6th
    pulse_clear();
    load_word(16'h2345);
    instr_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      chk("t4_stall_v", instr_valid, 1);
      chk("t4_stall_w", instr_word, 16'h2345);
      chk("t4_stall_pc", pc, 0);
      step();
    end
    chk("t4_v6", instr_valid, 1);
    instr_ready = 1'b1;
    step(); chk("t4_wb", instr_valid, 0); chk("t4_wb_busy", busy, 1);
    step(); chk("t4_done", done, 1);

    // start+clear together in DONE: clear wins; lone start with empty program ignored
    start = 1'b1; clear = 1'b1;
    step();
    start = 1'b0; clear = 1'b0;
    chk("t5_done", done, 0); chk("t5_busy", busy, 0); chk("t5_count", count, 0);
    chk("t5_valid", instr_valid, 0); chk("t5_lrdy", load_ready, 1);
    pulse_start();
    chk("t5_ign_busy", busy, 0); chk("t5_ign_valid", instr_valid, 0);
    step(); chk("t5_ign_valid2", instr_valid, 0);

    // Async reset in WB, then normal reuse
    load_word(16'h1111); load_word(16'h2222);
    pulse_start();
    chk("t6_v", instr_valid, 1);
    step();
    chk("t6_in_wb", busy, 1);
    rst = 1'b1;
    #1;
    chk_reset_vals("t6_arst");
    #2 rst = 1'b0;
    step();
    load_word(16'h7111);
    pulse_start();
    chk("t6_v_re", instr_valid, 1); chk("t6_w_re", instr_word, 16'h7111);
    step(); step();
    chk("t6_done", done, 1); chk("t6_count", count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
